iq_nco: RTL and testbench

- Parametrised numerically controlled oscillator. Generates a phase-coherent cosine/sine (I/Q) pair from a phase accumulator.
- Succeeds the flat full-wave combinational sine table:
  - quarter-wave ROM with symmetry folding;
  - signed outputs;
  - programmable frequency tuning word and phase offset;
  - registered 3-stage pipeline with valid tracking.
- Feeds the IQ modulator mixer stage directly.

---
 rtl/nco_pkg.sv | 26 ++
 rtl/quarter_sin_rom.sv | 55 +++++
 rtl/iq_nco.sv | 126 ++++++++++++
 tb/tb_iq_nco.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/nco_pkg.sv
// Shared types and helpers for the I/Q oscillator: quadrant type, symmetry fold, pipeline depth.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package nco_pkg;

  // Two-bit quadrant index taken from the top of the phase word.
  typedef logic [1:0] quad_t;

  // How a quarter-wave lookup is turned into a full-wave value.
  typedef struct packed {
    logic mirror;  // read T[~idx] instead of T[idx]
    logic negate;  // output is -T[...]
  } fold_t;

  // Cycles from the edge that samples en to the cycle out_valid is high.
  localparam int LATENCY = 3;

  // Quadrant 0: +T[idx], 1: +T[~idx], 2: -T[idx], 3: -T[~idx].
  function automatic fold_t fold(input quad_t q);
    fold_t f;
    f.mirror = q[0];
    f.negate = q[1];
    return f;
  endfunction

endpackage

// File: rtl/quarter_sin_rom.sv
// Quarter-wave sine magnitude table with two independent read ports.
// Latency: 1 cycle, address to registered data.
// Backpressure: none; reads every cycle.
module quarter_sin_rom #(
  parameter int    ADDR_W   = 8,
  parameter int    DAT_W    = 9,
  parameter string MEM_FILE = "sin_quarter_hex.mem"
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  output logic [DAT_W-1:0]  dat_a,
  output logic [DAT_W-1:0]  dat_b
);

  localparam int     DEPTH  = 1 << ADDR_W;
  localparam int     AMP    = (1 << DAT_W) - 1;
  localparam longint PI_Q30 = 64'sd3373259426;  // pi scaled by 2^30

  logic [DAT_W-1:0] mem [DEPTH];

  // round(AMP * sin(pi*(2k+1)/(4*DEPTH))) in Q30 fixed point via a Taylor series.
  function automatic logic [DAT_W-1:0] sin_entry(input int k);
    longint x, x2, t, s, r;
    x  = (PI_Q30 * longint'(2 * k + 1)) / longint'(4 * DEPTH);
    x2 = (x * x) >>> 30;
    t  = x;
    s  = x;
    for (int n = 1; n <= 10; n++) begin
      t = -((t * x2) >>> 30) / longint'((2 * n) * (2 * n + 1));
      s = s + t;
    end
    r = (longint'(AMP) * s + (longint'(1) <<< 29)) >>> 30;
    return r[DAT_W-1:0];
  endfunction

  generate
    for (genvar k = 0; k < DEPTH; k++) begin : g_ent
      assign mem[k] = sin_entry(k);
    end
  endgenerate

  // Registered dual read.
  always_ff @(posedge clk) begin
    if (rst) begin
      dat_a <= '0;
      dat_b <= '0;
    end else begin
      dat_a <= mem[addr_a];
      dat_b <= mem[addr_b];
    end
  end

endmodule

// File: rtl/iq_nco.sv
// NCO producing signed cosine (I) / sine (Q) from a phase accumulator and a folded quarter ROM.
// Latency: 3 cycles from the en-sampling edge to out_valid; one sample per cycle.
// Backpressure: none; the pipeline runs freely and en gaps appear as out_valid gaps.
module iq_nco
  import nco_pkg::*;
#(
  parameter int    BIT_DEPTH  = 10,
  parameter int    PHASE_W    = 32,
  parameter int    LUT_ADDR_W = 8,  // LUT_ADDR_W+2 must not exceed PHASE_W
  parameter string MEM_FILE   = "sin_quarter_hex.mem"
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [PHASE_W-1:0]          ftw_i,
  input  logic                        ftw_load,
  input  logic [PHASE_W-1:0]          phase_ofs_i,
  input  logic                        phase_clr,
  output logic                        out_valid,
  output logic signed [BIT_DEPTH-1:0] I_sin,
  output logic signed [BIT_DEPTH-1:0] Q_sin,
  output logic                        wrap_o
);

  localparam int TOP_W = LUT_ADDR_W + 2;
  localparam int MAG_W = BIT_DEPTH - 1;

  logic [PHASE_W-1:0] acc, ftw_reg, phase_sum;
  logic [PHASE_W:0]   acc_sum;
  logic               unused_phase;

  logic               v1, w1;
  logic [TOP_W-1:0]   p1;
  quad_t              qs1, qc1;
  logic [LUT_ADDR_W-1:0] idx1, addr_s, addr_c;
  fold_t              fs1, fc1;

  logic               v2, w2, neg_s2, neg_c2;
  logic [MAG_W-1:0]   sin_mag2, cos_mag2;

  // Carry out of this sum is the sample's wrap flag.
  assign acc_sum      = {1'b0, acc} + {1'b0, ftw_reg};
  // Offset applies to the pre-advance accumulator; only the top bits address the table.
  assign phase_sum    = acc + phase_ofs_i;
  assign unused_phase = ^phase_sum;

  // Tuning word capture and accumulator update; clear wins over advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      ftw_reg <= '0;
    end else begin
      if (ftw_load) ftw_reg <= ftw_i;
      if (phase_clr)  acc <= '0;
      else if (en)    acc <= acc_sum[PHASE_W-1:0];
    end
  end

  // Stage 1: launch the sample's phase, valid and wrap flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      w1 <= 1'b0;
      p1 <= '0;
    end else begin
      v1 <= en;
      w1 <= en & ~phase_clr & acc_sum[PHASE_W];
      p1 <= phase_sum[PHASE_W-1 -: TOP_W];
    end
  end

  // Cosine is sine a quarter turn ahead, so its quadrant is one higher.
  assign qs1    = p1[TOP_W-1 -: 2];
  assign qc1    = qs1 + 2'd1;
  assign idx1   = p1[LUT_ADDR_W-1:0];
  assign fs1    = fold(qs1);
  assign fc1    = fold(qc1);
  assign addr_s = fs1.mirror ? ~idx1 : idx1;
  assign addr_c = fc1.mirror ? ~idx1 : idx1;

  quarter_sin_rom #(
    .ADDR_W   (LUT_ADDR_W),
    .DAT_W    (MAG_W),
    .MEM_FILE (MEM_FILE)
  ) u_rom (
    .clk    (clk),
    .rst    (rst),
    .addr_a (addr_s),
    .addr_b (addr_c),
    .dat_a  (sin_mag2),
    .dat_b  (cos_mag2)
  );

  // Stage 2: side-band flags travel alongside the ROM read.
  always_ff @(posedge clk) begin
    if (rst) begin
      v2     <= 1'b0;
      w2     <= 1'b0;
      neg_s2 <= 1'b0;
      neg_c2 <= 1'b0;
    end else begin
      v2     <= v1;
      w2     <= w1;
      neg_s2 <= fs1.negate;
      neg_c2 <= fc1.negate;
    end
  end

  // Stage 3: apply sign; sample registers hold while no new sample arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      wrap_o    <= 1'b0;
      I_sin     <= '0;
      Q_sin     <= '0;
    end else begin
      out_valid <= v2;
      wrap_o    <= w2;
      if (v2) begin
        I_sin <= neg_c2 ? -{1'b0, cos_mag2} : {1'b0, cos_mag2};
        Q_sin <= neg_s2 ? -{1'b0, sin_mag2} : {1'b0, sin_mag2};
      end
    end
  end

endmodule

// File: tb/tb_iq_nco.sv
// Scoreboard bench: stimulus pushes expected samples from a trigonometric model, a monitor pops and compares.
// Latency: expects each sample LATENCY cycles after the cycle that launched it.
// Backpressure: none; the monitor also checks gaps for held outputs.
module tb_iq_nco;
  import nco_pkg::*;

  localparam int  BD  = 10;
  localparam int  PW  = 32;
  localparam int  AW  = 8;
  localparam int  AMP = 511;
  localparam real PI  = 3.14159265358979323846;

  logic clk = 1'b0, rst = 1'b0, en = 1'b0, ftw_load = 1'b0, phase_clr = 1'b0;
  logic [PW-1:0] ftw_i = '0, phase_ofs_i = '0;
  logic out_valid, wrap_o;
  logic signed [BD-1:0] I_sin, Q_sin;

  typedef struct {
    int     i;
    int     q;
    bit     w;
    longint due;
    int     tag;
    int     grp;
  } exp_t;

  exp_t   sb[$];
  exp_t   mx;
  longint cyc = 0, rst_cyc = -1;
  int     total = 0, bad = 0, wraps1 = 0, last_i = 0, last_q = 0, grp_now = 0;
  bit     mon_on = 1'b0;
  logic [PW-1:0] m_acc = '0, m_ftw = '0;
  int     dir_i [7] = '{0, 511, -2, -511, 2, -2, 511};
  int     dir_q [7] = '{0, 2, 511, -2, -511, 511, 2};
  bit     pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  bit     r_e, r_c, r_l;
  int     tg;

  iq_nco #(
    .BIT_DEPTH  (BD),
    .PHASE_W    (PW),
    .LUT_ADDR_W (AW),
    .MEM_FILE   ("")
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .ftw_i       (ftw_i),
    .ftw_load    (ftw_load),
    .phase_ofs_i (phase_ofs_i),
    .phase_clr   (phase_clr),
    .out_valid   (out_valid),
    .I_sin       (I_sin),
    .Q_sin       (Q_sin),
    .wrap_o      (wrap_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int rnd(input real r);
    if (r >= 0.0) return $rtoi(r + 0.5);
    return -$rtoi(0.5 - r);
  endfunction

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // One clock of stimulus; the model predicts the sample from phase angle directly.
  task automatic drive(input bit r, input bit e, input bit clr, input bit ld,
                       input logic [PW-1:0] f, input logic [PW-1:0] o, input int tag);
    logic [PW-1:0] p;
    int            n;
    real           th;
    exp_t          x;
    rst = r; en = e; phase_clr = clr; ftw_load = ld; ftw_i = f; phase_ofs_i = o;
    if (r) begin
      while (sb.size() > 0 && sb[sb.size()-1].due > cyc) void'(sb.pop_back());
      m_acc   = '0;
      m_ftw   = '0;
      rst_cyc = cyc + 1;
    end else begin
      if (e) begin
        p     = m_acc + o;
        n     = int'(p >> (PW - AW - 2));
        th    = 2.0 * PI * (real'(n) + 0.5) / real'(1 << (AW + 2));
        x.i   = rnd(real'(AMP) * $cos(th));
        x.q   = rnd(real'(AMP) * $sin(th));
        x.w   = !clr && ((longint'(m_acc) + longint'(m_ftw)) >= (longint'(1) << PW));
        x.due = cyc + LATENCY;
        x.tag = tag;
        x.grp = grp_now;
        sb.push_back(x);
      end
      if (clr)    m_acc = '0;
      else if (e) m_acc = m_acc + m_ftw;
      if (ld)     m_ftw = f;
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare whatever the DUT presents against the scoreboard head.
  always @(negedge clk) begin
    if (mon_on) begin
      if (cyc == rst_cyc) begin
        last_i = 0;
        last_q = 0;
      end
      while (sb.size() > 0 && sb[0].due < cyc) begin
        void'(sb.pop_front());
        check("missed_sample", 0, 1);
      end
      if (sb.size() > 0 && sb[0].due == cyc) begin
        mx = sb.pop_front();
        check("valid", int'(out_valid), 1);
        check("i", int'(I_sin), mx.i);
        check("q", int'(Q_sin), mx.q);
        check("wrap", int'(wrap_o), int'(mx.w));
        if (mx.tag > 0) begin
          check("dir_i", int'(I_sin), dir_i[mx.tag]);
          check("dir_q", int'(Q_sin), dir_q[mx.tag]);
        end
        if (mx.grp == 1 && wrap_o === 1'b1) wraps1++;
        last_i = mx.i;
        last_q = mx.q;
      end else begin
        check("gap_valid", int'(out_valid), 0);
        check("hold_i", int'(I_sin), last_i);
        check("hold_q", int'(Q_sin), last_q);
        check("gap_wrap", int'(wrap_o), 0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset, then load a tuning word of 1/1024 turn.
    drive(1, 0, 0, 0, '0, '0, 0);
    mon_on = 1'b1;
    drive(1, 0, 0, 0, '0, '0, 0);
    drive(0, 0, 0, 1, 32'h0040_0000, '0, 0);

    // Two full periods with zero offset; quadrant seams checked directly.
    grp_now = 1;
    for (int k = 0; k < 2048; k++) begin
      tg = (k == 0) ? 1 : (k == 256) ? 2 : (k == 512) ? 3 : (k == 768) ? 4 : 0;
      drive(0, 1, 0, 0, '0, '0, tg);
    end
    grp_now = 0;
    drive(0, 0, 0, 0, '0, '0, 0);
    drive(0, 0, 0, 0, '0, '0, 0);
    drive(0, 0, 0, 0, '0, '0, 0);
    check("wrap_count", wraps1, 2);

    // Quarter-turn offset from a cleared accumulator.
    drive(0, 0, 1, 0, '0, '0, 0);
    for (int k = 0; k < 300; k++) drive(0, 1, 0, 0, '0, 32'h4000_0000, (k == 0) ? 5 : 0);

    // en gaps.
    for (int rep = 0; rep < 4; rep++)
      for (int j = 0; j < 5; j++) drive(0, pat[j], 0, 0, '0, '0, 0);

    // Tuning word change mid-stream, then clear together with en.
    for (int k = 0; k < 6; k++) drive(0, 1, 0, 0, '0, '0, 0);
    drive(0, 1, 0, 1, 32'h0080_0000, '0, 0);
    for (int k = 0; k < 6; k++) drive(0, 1, 0, 0, '0, '0, 0);
    drive(0, 1, 1, 0, '0, '0, 0);
    drive(0, 1, 0, 0, '0, '0, 6);
    for (int k = 0; k < 4; k++) drive(0, 1, 0, 0, '0, '0, 0);

    // Reset with three samples in flight, then restart from zero phase.
    drive(0, 1, 0, 0, '0, 32'h1234_5678, 0);
    drive(0, 1, 0, 0, '0, 32'h1234_5678, 0);
    drive(1, 1, 0, 0, '0, 32'h1234_5678, 0);
    drive(0, 0, 0, 1, 32'h0040_0000, '0, 0);
    drive(0, 1, 0, 0, '0, '0, 6);
    for (int k = 0; k < 8; k++) drive(0, 1, 0, 0, '0, '0, 0);

    // Random traffic.
    for (int k = 0; k < 600; k++) begin
      r_e = ($urandom_range(3) != 0);
      r_c = ($urandom_range(31) == 0);
      r_l = ($urandom_range(15) == 0);
      drive(0, r_e, r_c, r_l, $urandom(), $urandom(), 0);
    end

    // Drain.
    for (int k = 0; k < 6; k++) drive(0, 0, 0, 0, '0, '0, 0);
    check("drain", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
